// File: rtl/mem_write_monitor.sv
// In-order store checker for a data-memory write bus: compares committed stores against a loadable
// expected (address, data) table and latches a sticky pass/fail verdict. Optional watchdog: MEM_WRITE_MONITOR_TIMEOUT_EN.
module mem_write_monitor #(
    parameter int              AW         = 32,
    parameter int              DW         = 32,
    parameter int              DEPTH      = 8,
    parameter bit              IGNORE_EN  = 1'b1,
    parameter logic [AW-1:0]   IGNORE_ADR = 32'd96,
    parameter int              TIMEOUT    = 1024,
    localparam int             IW         = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          MemWrite,
    input  logic [AW-1:0] DataAdr,
    input  logic [DW-1:0] WriteData,
    input  logic          cfg_we,
    input  logic [IW-1:0] cfg_idx,
    input  logic [AW-1:0] cfg_adr,
    input  logic [DW-1:0] cfg_data,
    input  logic [IW:0]   cfg_count,
    input  logic          start,
    output logic          armed,
    output logic          pass,
    output logic          fail,
    output logic [1:0]    fail_code,
    output logic [IW-1:0] fail_idx,
    output logic [AW-1:0] fail_adr,
    output logic [DW-1:0] fail_data,
    output logic [15:0]   nwrites
);

    typedef enum logic [1:0] {IDLE, ARMED, PASS_ST, FAIL_ST} state_t;

    localparam logic [IW:0] DEPTH_C = (IW+1)'(DEPTH);

    state_t        state_r, state_next;
    logic [IW-1:0] ptr_r, ptr_next;
    logic [IW:0]   count_r, count_next;
    logic [15:0]   nwrites_r, nwrites_next;
    logic [1:0]    code_r, code_next;
    logic [IW-1:0] fidx_r, fidx_next;
    logic [AW-1:0] fadr_r, fadr_next;
    logic [DW-1:0] fdata_r, fdata_next;
    logic          armed_r, pass_r, fail_r;
    logic          hit_s, last_s, ign_s;

    logic [AW-1:0] tbl_adr  [DEPTH];
    logic [DW-1:0] tbl_data [DEPTH];

`ifdef MEM_WRITE_MONITOR_TIMEOUT_EN
    localparam int CTW = $clog2(TIMEOUT) + 1;
    logic [CTW-1:0] cyc_r, cyc_next;
    logic           timeout_s;
    assign timeout_s = (cyc_r == CTW'(TIMEOUT - 1));
`endif

    assign hit_s  = (DataAdr == tbl_adr[ptr_r]) && (WriteData == tbl_data[ptr_r]);
    assign last_s = (({1'b0, ptr_r} + (IW+1)'(1)) == count_r);
    assign ign_s  = (IGNORE_EN != 1'b0) && (DataAdr == IGNORE_ADR);

    // Expected-table storage; contents deliberately survive reset so a rerun can reuse them.
    always_ff @(posedge clk) begin
        if (cfg_we && (state_r != ARMED)) begin
            tbl_adr[cfg_idx]  <= cfg_adr;
            tbl_data[cfg_idx] <= cfg_data;
        end
    end

    // Next-state and capture logic.
    always_comb begin
        state_next   = state_r;
        ptr_next     = ptr_r;
        count_next   = count_r;
        nwrites_next = nwrites_r;
        code_next    = code_r;
        fidx_next    = fidx_r;
        fadr_next    = fadr_r;
        fdata_next   = fdata_r;
`ifdef MEM_WRITE_MONITOR_TIMEOUT_EN
        cyc_next     = cyc_r;
`endif
        case (state_r)
            ARMED: begin
                if (MemWrite) begin
                    if (nwrites_r != 16'hFFFF) begin
                        nwrites_next = nwrites_r + 16'd1;
                    end else begin
                        nwrites_next = nwrites_r;
                    end
                    // A table match wins over the scratch-address tolerance.
                    if (hit_s) begin
                        if (last_s) begin
                            state_next = PASS_ST;
                        end else begin
                            ptr_next = ptr_r + IW'(1);
                        end
                    end else if (ign_s) begin
                        state_next = ARMED;
                    end else begin
                        state_next = FAIL_ST;
                        code_next  = 2'd1;
                        fidx_next  = ptr_r;
                        fadr_next  = DataAdr;
                        fdata_next = WriteData;
                    end
                end else begin
                    nwrites_next = nwrites_r;
                end
`ifdef MEM_WRITE_MONITOR_TIMEOUT_EN
                if (timeout_s && (state_next == ARMED)) begin
                    state_next = FAIL_ST;
                    code_next  = 2'd2;
                    fidx_next  = ptr_next;
                    fadr_next  = {AW{1'b0}};
                    fdata_next = {DW{1'b0}};
                end else begin
                    cyc_next = cyc_r + CTW'(1);
                end
`endif
            end
            default: begin
                if (start) begin
                    if (cfg_count > DEPTH_C) begin
                        count_next = DEPTH_C;
                    end else begin
                        count_next = cfg_count;
                    end
                    ptr_next     = {IW{1'b0}};
                    nwrites_next = 16'd0;
                    code_next    = 2'd0;
                    fidx_next    = {IW{1'b0}};
                    fadr_next    = {AW{1'b0}};
                    fdata_next   = {DW{1'b0}};
`ifdef MEM_WRITE_MONITOR_TIMEOUT_EN
                    cyc_next     = {CTW{1'b0}};
`endif
                    if (count_next == {(IW+1){1'b0}}) begin
                        state_next = PASS_ST;
                    end else begin
                        state_next = ARMED;
                    end
                end else begin
                    state_next = state_r;
                end
            end
        endcase
    end

    // State, status and capture registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= IDLE;
            ptr_r     <= {IW{1'b0}};
            count_r   <= {(IW+1){1'b0}};
            nwrites_r <= 16'd0;
            code_r    <= 2'd0;
            fidx_r    <= {IW{1'b0}};
            fadr_r    <= {AW{1'b0}};
            fdata_r   <= {DW{1'b0}};
            armed_r   <= 1'b0;
            pass_r    <= 1'b0;
            fail_r    <= 1'b0;
`ifdef MEM_WRITE_MONITOR_TIMEOUT_EN
            cyc_r     <= {CTW{1'b0}};
`endif
        end else begin
            state_r   <= state_next;
            ptr_r     <= ptr_next;
            count_r   <= count_next;
            nwrites_r <= nwrites_next;
            code_r    <= code_next;
            fidx_r    <= fidx_next;
            fadr_r    <= fadr_next;
            fdata_r   <= fdata_next;
            armed_r   <= (state_next == ARMED);
            pass_r    <= (state_next == PASS_ST);
            fail_r    <= (state_next == FAIL_ST);
`ifdef MEM_WRITE_MONITOR_TIMEOUT_EN
            cyc_r     <= cyc_next;
`endif
        end
    end

    assign armed     = armed_r;
    assign pass      = pass_r;
    assign fail      = fail_r;
    assign fail_code = code_r;
    assign fail_idx  = fidx_r;
    assign fail_adr  = fadr_r;
    assign fail_data = fdata_r;
    assign nwrites   = nwrites_r;

endmodule

// File: tb/tb_mem_write_monitor.sv
// Directed bench for mem_write_monitor: default DUT, a scratch-tolerance-disabled copy, and (with
// MEM_WRITE_MONITOR_TIMEOUT_EN) a short-watchdog copy.
module tb_mem_write_monitor;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        MemWrite = 1'b0;
    logic [31:0] DataAdr = 32'd0;
    logic [31:0] WriteData = 32'd0;
    logic        cfg_we = 1'b0;
    logic [2:0]  cfg_idx = 3'd0;
    logic [31:0] cfg_adr = 32'd0;
    logic [31:0] cfg_data = 32'd0;
    logic [3:0]  cfg_count = 4'd0;
    logic        start = 1'b0;

    logic        armed, pass, fail;
    logic [1:0]  fail_code;
    logic [2:0]  fail_idx;
    logic [31:0] fail_adr, fail_data;
    logic [15:0] nwrites;

    logic        n_armed, n_pass, n_fail;
    logic [1:0]  n_code;
    logic [2:0]  n_idx;
    logic [31:0] n_adr, n_data;
    logic [15:0] n_nwrites;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    mem_write_monitor u_dut (
        .clk(clk), .reset(reset), .MemWrite(MemWrite), .DataAdr(DataAdr), .WriteData(WriteData),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_adr(cfg_adr), .cfg_data(cfg_data),
        .cfg_count(cfg_count), .start(start), .armed(armed), .pass(pass), .fail(fail),
        .fail_code(fail_code), .fail_idx(fail_idx), .fail_adr(fail_adr), .fail_data(fail_data),
        .nwrites(nwrites)
    );

    mem_write_monitor #(.IGNORE_EN(1'b0)) u_noign (
        .clk(clk), .reset(reset), .MemWrite(MemWrite), .DataAdr(DataAdr), .WriteData(WriteData),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_adr(cfg_adr), .cfg_data(cfg_data),
        .cfg_count(cfg_count), .start(start), .armed(n_armed), .pass(n_pass), .fail(n_fail),
        .fail_code(n_code), .fail_idx(n_idx), .fail_adr(n_adr), .fail_data(n_data),
        .nwrites(n_nwrites)
    );

`ifdef MEM_WRITE_MONITOR_TIMEOUT_EN
    logic        t_armed, t_pass, t_fail;
    logic [1:0]  t_code;
    logic [2:0]  t_idx;
    logic [31:0] t_adr, t_data;
    logic [15:0] t_nwrites;

    mem_write_monitor #(.TIMEOUT(16)) u_tmo (
        .clk(clk), .reset(reset), .MemWrite(MemWrite), .DataAdr(DataAdr), .WriteData(WriteData),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_adr(cfg_adr), .cfg_data(cfg_data),
        .cfg_count(cfg_count), .start(start), .armed(t_armed), .pass(t_pass), .fail(t_fail),
        .fail_code(t_code), .fail_idx(t_idx), .fail_adr(t_adr), .fail_data(t_data),
        .nwrites(t_nwrites)
    );
`endif

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [2:0] idx, input logic [31:0] adr, input logic [31:0] data);
        cfg_we = 1'b1; cfg_idx = idx; cfg_adr = adr; cfg_data = data;
        cyc();
        cfg_we = 1'b0;
    endtask

    task automatic arm(input logic [3:0] cnt);
        cfg_count = cnt; start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic store(input logic [31:0] adr, input logic [31:0] data);
        MemWrite = 1'b1; DataAdr = adr; WriteData = data;
        cyc();
        MemWrite = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        total++; if ({armed, pass, fail} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b exp=000", {armed, pass, fail}); end
        total++; if ({fail_code, fail_idx, nwrites} !== 21'd0) begin bad++; $display("FAIL reset_fields got=%0h exp=0", {fail_code, fail_idx, nwrites}); end
        total++; if ({fail_adr, fail_data} !== 64'd0) begin bad++; $display("FAIL reset_capture got=%0h exp=0", {fail_adr, fail_data}); end
        @(negedge clk);
        reset = 1'b0;
        cyc();
    endtask

    task automatic test_scratch_then_match();
        load(3'd0, 32'd100, 32'd7);
        arm(4'd1);
        total++; if (armed !== 1'b1) begin bad++; $display("FAIL armed_after_start got=%b exp=1", armed); end
        store(32'd96, 32'd5);
        total++; if ({armed, pass, fail} !== 3'b100) begin bad++; $display("FAIL scratch_tolerated got=%b exp=100", {armed, pass, fail}); end
        total++; if ({n_fail, n_code, n_idx} !== 6'b1_01_000) begin bad++; $display("FAIL noign_fail got=%b exp=101000", {n_fail, n_code, n_idx}); end
        total++; if ({n_adr, n_data} !== {32'd96, 32'd5}) begin bad++; $display("FAIL noign_capture got=%0h exp=%0h", {n_adr, n_data}, {32'd96, 32'd5}); end
        store(32'd100, 32'd7);
        total++; if ({armed, pass, fail} !== 3'b010) begin bad++; $display("FAIL match_pass got=%b exp=010", {armed, pass, fail}); end
        total++; if (nwrites !== 16'd2) begin bad++; $display("FAIL match_nwrites got=%0d exp=2", nwrites); end
    endtask

    task automatic test_mismatch();
        arm(4'd1);
        total++; if ({armed, pass, fail} !== 3'b100) begin bad++; $display("FAIL rearm_clears got=%b exp=100", {armed, pass, fail}); end
        store(32'd104, 32'd7);
        total++; if ({armed, pass, fail, fail_code, fail_idx} !== 8'b001_01_000) begin bad++; $display("FAIL mismatch_status got=%b exp=00101000", {armed, pass, fail, fail_code, fail_idx}); end
        total++; if ({fail_adr, fail_data} !== {32'd104, 32'd7}) begin bad++; $display("FAIL mismatch_capture got=%0h exp=%0h", {fail_adr, fail_data}, {32'd104, 32'd7}); end
        total++; if (nwrites !== 16'd1) begin bad++; $display("FAIL mismatch_nwrites got=%0d exp=1", nwrites); end
    endtask

    task automatic test_start_overlap();
        MemWrite = 1'b1; DataAdr = 32'd200; WriteData = 32'd0;
        arm(4'd1);
        MemWrite = 1'b0;
        total++; if ({armed, fail, fail_code} !== 4'b1000) begin bad++; $display("FAIL overlap_unchecked got=%b exp=1000", {armed, fail, fail_code}); end
        total++; if (nwrites !== 16'd0) begin bad++; $display("FAIL overlap_nwrites got=%0d exp=0", nwrites); end
        load(3'd0, 32'd200, 32'd9);
        store(32'd100, 32'd7);
        total++; if ({armed, pass, fail} !== 3'b010) begin bad++; $display("FAIL cfg_locked_while_armed got=%b exp=010", {armed, pass, fail}); end
    endtask

    task automatic test_sequence();
        load(3'd0, 32'd80, 32'd1);
        load(3'd1, 32'd84, 32'd2);
        load(3'd2, 32'd88, 32'd3);
        arm(4'd3);
        store(32'd80, 32'd1);
        store(32'd84, 32'd2);
        total++; if ({armed, pass, fail} !== 3'b100) begin bad++; $display("FAIL seq_midway got=%b exp=100", {armed, pass, fail}); end
        store(32'd88, 32'd3);
        total++; if ({armed, pass, fail, nwrites} !== {3'b010, 16'd3}) begin bad++; $display("FAIL seq_pass got=%0h exp=%0h", {armed, pass, fail, nwrites}, {3'b010, 16'd3}); end
        arm(4'd3);
        store(32'd80, 32'd1);
        store(32'd88, 32'd3);
        total++; if ({pass, fail, fail_code, fail_idx} !== 7'b01_01_001) begin bad++; $display("FAIL swap_fail got=%b exp=0101001", {pass, fail, fail_code, fail_idx}); end
        total++; if ({fail_adr, fail_data} !== {32'd88, 32'd3}) begin bad++; $display("FAIL swap_capture got=%0h exp=%0h", {fail_adr, fail_data}, {32'd88, 32'd3}); end
    endtask

    task automatic test_reset_mid_run();
        arm(4'd3);
        store(32'd80, 32'd1);
        store(32'd84, 32'd2);
        reset = 1'b1;
        #1;
        total++; if ({armed, pass, fail, fail_code, fail_idx, nwrites} !== 24'd0) begin bad++; $display("FAIL async_reset got=%0h exp=0", {armed, pass, fail, fail_code, fail_idx, nwrites}); end
        @(negedge clk);
        reset = 1'b0;
        cyc();
        arm(4'd3);
        store(32'd80, 32'd1);
        store(32'd84, 32'd2);
        store(32'd88, 32'd3);
        total++; if ({armed, pass, fail, nwrites} !== {3'b010, 16'd3}) begin bad++; $display("FAIL retained_table got=%0h exp=%0h", {armed, pass, fail, nwrites}, {3'b010, 16'd3}); end
    endtask

    task automatic test_count_bounds();
        arm(4'd0);
        total++; if ({armed, pass, fail, nwrites} !== {3'b010, 16'd0}) begin bad++; $display("FAIL count_zero got=%0h exp=%0h", {armed, pass, fail, nwrites}, {3'b010, 16'd0}); end
        for (int i = 0; i < 8; i++) load(3'(i), 32'(200 + 4 * i), 32'(10 + i));
        arm(4'd15);
        for (int i = 0; i < 7; i++) store(32'(200 + 4 * i), 32'(10 + i));
        total++; if ({armed, pass, fail} !== 3'b100) begin bad++; $display("FAIL clamp_before_last got=%b exp=100", {armed, pass, fail}); end
        store(32'd228, 32'd17);
        total++; if ({armed, pass, fail, nwrites} !== {3'b010, 16'd8}) begin bad++; $display("FAIL clamp_pass got=%0h exp=%0h", {armed, pass, fail, nwrites}, {3'b010, 16'd8}); end
    endtask

`ifdef MEM_WRITE_MONITOR_TIMEOUT_EN
    task automatic test_timeout();
        arm(4'd1);
        for (int i = 0; i < 15; i++) cyc();
        total++; if ({t_armed, t_fail} !== 2'b10) begin bad++; $display("FAIL tmo_early got=%b exp=10", {t_armed, t_fail}); end
        cyc();
        total++; if ({t_armed, t_pass, t_fail, t_code, t_idx} !== 8'b001_10_000) begin bad++; $display("FAIL tmo_fail got=%b exp=00110000", {t_armed, t_pass, t_fail, t_code, t_idx}); end
        total++; if ({t_adr, t_data} !== 64'd0) begin bad++; $display("FAIL tmo_capture got=%0h exp=0", {t_adr, t_data}); end
        arm(4'd1);
        for (int i = 0; i < 15; i++) cyc();
        store(32'd200, 32'd10);
        total++; if ({t_pass, t_fail, t_code} !== 4'b1000) begin bad++; $display("FAIL tmo_store_wins got=%b exp=1000", {t_pass, t_fail, t_code}); end
    endtask
`endif

    initial begin
        test_reset();
        test_scratch_then_match();
        test_mismatch();
        test_start_overlap();
        test_sequence();
        test_reset_mid_run();
        test_count_bounds();
`ifdef MEM_WRITE_MONITOR_TIMEOUT_EN
        test_timeout();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "bench did not finish");
    end

endmodule
